dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the word-organised data memory (4 byte-lane write enables, word address).
//  Shares the memory between the core MEM stage (byte/half/word, any alignment) and an aux word port (loader/debug).
//  Splits misaligned core accesses into two word beats, builds byte enables, and sign/zero-extends load data.
//  Stalls the core while an access is in flight.
// PARAMETERS
//  DM_ADDRESS       9  byte-address width; memory holds 2**(DM_ADDRESS-2) words
//  DATA_W          32  data width (fixed 32; lanes = 4)
//  ALLOW_MISALIGNED 1  1: split cross-word accesses into 2 beats; 0: misaligned -> c_err, no access
//  STARVE_LIM       4  aux cycles-waiting limit before it beats a pending core request
// PORTS
//  clk        in  1             clock; all state updates on rising edge
//  reset      in  1             asynchronous, active-high reset
//  c_req      in  1             core access request (held until c_done)
//  c_we       in  1             1 store, 0 load
//  c_funct3   in  3             instr[14:12]: LB/LH/LW/LBU/LHU, SB/SH/SW
//  c_addr     in  DM_ADDRESS    byte address
//  c_wdata    in  32            store data (right-aligned)
//  c_rdata    out 32            extended load data, valid with c_done
//  c_done     out 1             one-cycle completion pulse
//  c_err      out 1             with c_done: illegal funct3 / misaligned disallowed / top-of-memory crossing
//  c_stall    out 1             c_req & ~c_done (combinational)
//  a_req      in  1             aux word request (held until a_done)
//  a_we       in  1             1 write full word, 0 read
//  a_addr     in  DM_ADDRESS-2  word address
//  a_wdata    in  32            aux write data
//  a_rdata    out 32            aux read data, valid with a_done
//  a_done     out 1             one-cycle completion pulse
//  mem_addr   out DM_ADDRESS-2  word address to memory
//  mem_wdata  out 32            lane-aligned write data
//  mem_be     out 4             byte write enables; 0000 = read-only beat
//  mem_rdata  in  32            word at previous-cycle mem_addr (1-cycle read latency)
// BEHAVIOUR
//  Reset: state IDLE; mem_be=0, mem_addr=0, mem_wdata=0, c_done=c_err=a_done=0, c_rdata=a_rdata=0, starve cnt=0.
//  FSM IDLE -> ISSUE0 -> [ISSUE1] -> RESP -> IDLE.
//   IDLE: arbitrate, latch winner's request (later changes to inputs ignored); mem_be=0.
//   ISSUE0: drive beat0 (word addr[DM_ADDRESS-1:2]); ->ISSUE1 if split, else RESP.
//   ISSUE1: capture beat0 rdata; drive beat1 (word+1).
//   RESP: capture last rdata; assemble/extend; pulse done (+err); mem_be=0.
//  Latency accept->done: 3 cycles aligned, 4 split; back-to-back accept possible the cycle after RESP.
//  Arbitration: core wins ties; aux starve cnt increments each IDLE cycle aux loses, clears on aux grant;
//   cnt==STARVE_LIM -> aux wins next IDLE.
//  Size: funct3[1:0] 00=1B, 01=2B, 10=4B; funct3[2]=1 -> zero-extend (LBU/LHU), else sign-extend.
//  Illegal: 011,110,111 any; 100/101 with we=1; all -> no write (be=0), go direct ISSUE0->RESP, err=1, rdata=0.
//  Lane math: o=addr[1:0], S=size; mask8=((1<<S)-1)<<o; data64=wdata<<(8*o);
//   beat0 be=mask8[3:0], wdata=data64[31:0]; beat1 be=mask8[7:4], wdata=data64[63:32].
//   Split iff o+S>4; load word = ({beat1,beat0}>>(8*o)) truncated to S, then extended.
//  Split with beat0 word = last word: err, no access (no wrap-around). ALLOW_MISALIGNED=0: any split -> err.
//  Aux: always be=1111 on write, 0000 on read; one beat; a_rdata=mem_rdata captured in RESP.
//  Reset mid-operation: immediate return to IDLE, no done pulse; a split store may leave beat0 written.
// STRUCTURE
//  dmem_pkg: funct3 localparams (F3_B/H/W/BU/HU), state_t enum, size_of(funct3), is_legal(funct3,we).
//  Sub-module dmem_lane_align (combinational): offset/size/wdata -> {be,data} per beat; beats+offset -> extended rdata.
//  Top: FSM, request latch, starve counter, beat0 rdata register.
// TESTING
//  SW 0xDEADBEEF @0x010, LW @0x010 -> mem word 4 = DEADBEEF, be=1111 one beat; c_rdata=DEADBEEF, done 3 cyc after accept.
//  word4=0x80FF7F01: LB @0x013 -> FFFFFF80; LBU @0x013 -> 00000080; LH @0x012 -> FFFF80FF; LHU -> 000080FF.
//  SW 0x11223344 @0x013 -> beat0 word4 be=1000 lane3=44, beat1 word5 be=0111 =112233; LW @0x013 -> 11223344, 4 cyc.
//  SH @0x1FF (last word, split) -> c_err=1, mem_be stays 0; funct3=011 -> c_err=1, rdata=0.
//  c_req held continuously, a_req asserted -> aux granted after exactly STARVE_LIM lost IDLE cycles; a_done once.
//  Assert reset during ISSUE1 of split store -> outputs reset values next cycle, no c_done, FSM accepts new req after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE0, ST_ISSUE1, ST_RESP} state_t;

  // Access size in bytes; the reserved size code maps to 4 and is rejected by is_legal.
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: is_legal = 1'b1;
      F3_BU, F3_HU:     is_legal = ~we;
      default:          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a two-beat window: store lanes/enables per beat, and
// load extraction plus sign/zero extension from the concatenated beats.
module dmem_lane_align (
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic        i_zext,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rbeats,
  output logic [3:0]  o_be0,
  output logic [3:0]  o_be1,
  output logic [31:0] o_wd0,
  output logic [31:0] o_wd1,
  output logic        o_split,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask;
  logic [63:0] w_data64;
  logic [31:0] w_rword;
  logic        w_sext;

  assign w_mask   = ((8'd1 << i_size) - 8'd1) << i_off;
  assign w_data64 = {32'd0, i_wdata} << {i_off, 3'b000};

  assign {o_be1, o_be0} = w_mask;
  assign {o_wd1, o_wd0} = w_data64;
  assign o_split        = ({2'b00, i_off} + {1'b0, i_size}) > 4'd4;

  // Beat1 sits above beat0, so one right shift lines up any straddling load.
  assign w_rword = 32'(i_rbeats >> {i_off, 3'b000});
  assign w_sext  = ~i_zext;

  always_comb begin
    case (i_size)
      3'd1:    o_rdata = {{24{w_sext & w_rword[7]}}, w_rword[7:0]};
      3'd2:    o_rdata = {{16{w_sext & w_rword[15]}}, w_rword[15:0]};
      default: o_rdata = w_rword;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbiter/sequencer sharing a word-organised data memory between the core MEM
// stage (any size/alignment, split into two beats when needed) and an aux word port.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS       = 9,
  parameter int DATA_W           = 32,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int STARVE_LIM       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [2:0]            c_funct3,
  input  logic [DM_ADDRESS-1:0] c_addr,
  input  logic [DATA_W-1:0]     c_wdata,
  output logic [DATA_W-1:0]     c_rdata,
  output logic                  c_done,
  output logic                  c_err,
  output logic                  c_stall,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DM_ADDRESS-3:0] a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_done,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int AW = DM_ADDRESS - 2;
  localparam int CW = $clog2(STARVE_LIM + 1);

  state_t        r_state;
  logic          r_is_aux, r_we, r_err, r_split;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [31:0]   r_wdata, r_beat0;
  logic [CW-1:0] r_starve;

  logic          w_idle, w_aux_win, w_core_win, w_split, w_c_err;
  logic [2:0]    w_f3;
  logic [1:0]    w_off;
  logic [31:0]   w_wdata, w_wd0, w_wd1, w_rdata_ext;
  logic [3:0]    w_be0, w_be1;
  logic [63:0]   w_rbeats;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_aux_win  = a_req & (~c_req | (r_starve == CW'(STARVE_LIM)));
  assign w_core_win = c_req & ~w_aux_win;

  // While idle the aligner looks at the live core request so beat0 can be registered on accept.
  assign w_f3     = w_idle ? c_funct3 : r_f3;
  assign w_off    = w_idle ? c_addr[1:0] : r_off;
  assign w_wdata  = w_idle ? c_wdata : r_wdata;
  assign w_rbeats = {mem_rdata, (r_split ? r_beat0 : mem_rdata)};

  dmem_lane_align u_align (
    .i_off    (w_off),
    .i_size   (size_of(w_f3)),
    .i_zext   (w_f3[2]),
    .i_wdata  (w_wdata),
    .i_rbeats (w_rbeats),
    .o_be0    (w_be0),
    .o_be1    (w_be1),
    .o_wd0    (w_wd0),
    .o_wd1    (w_wd1),
    .o_split  (w_split),
    .o_rdata  (w_rdata_ext)
  );

  assign w_c_err = ~is_legal(c_funct3, c_we) |
                   (w_split & ((ALLOW_MISALIGNED == 0) | (&c_addr[DM_ADDRESS-1:2])));

  assign c_stall = c_req & ~c_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_is_aux  <= 1'b0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_split   <= 1'b0;
      r_f3      <= 3'd0;
      r_off     <= 2'd0;
      r_wdata   <= 32'd0;
      r_beat0   <= 32'd0;
      r_starve  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'd0;
      c_rdata   <= '0;
      c_done    <= 1'b0;
      c_err     <= 1'b0;
      a_rdata   <= '0;
      a_done    <= 1'b0;
    end else begin
      c_done <= 1'b0;
      c_err  <= 1'b0;
      a_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          mem_be <= 4'd0;
          if (w_aux_win) begin
            r_is_aux  <= 1'b1;
            r_we      <= a_we;
            r_err     <= 1'b0;
            r_split   <= 1'b0;
            r_starve  <= '0;
            mem_addr  <= a_addr;
            mem_wdata <= a_wdata;
            mem_be    <= {4{a_we}};
            r_state   <= ST_ISSUE0;
          end else if (w_core_win) begin
            r_is_aux  <= 1'b0;
            r_we      <= c_we;
            r_f3      <= c_funct3;
            r_off     <= c_addr[1:0];
            r_wdata   <= c_wdata;
            r_err     <= w_c_err;
            r_split   <= w_split & ~w_c_err;
            mem_addr  <= c_addr[DM_ADDRESS-1:2];
            mem_wdata <= w_wd0;
            mem_be    <= (c_we & ~w_c_err) ? w_be0 : 4'd0;
            if (a_req) r_starve <= r_starve + CW'(1);
            r_state   <= ST_ISSUE0;
          end
        end
        ST_ISSUE0: begin
          if (r_split) begin
            mem_addr  <= mem_addr + AW'(1);
            mem_wdata <= w_wd1;
            mem_be    <= r_we ? w_be1 : 4'd0;
            r_state   <= ST_ISSUE1;
          end else begin
            mem_be  <= 4'd0;
            r_state <= ST_RESP;
          end
        end
        ST_ISSUE1: begin
          r_beat0 <= mem_rdata;
          mem_be  <= 4'd0;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (r_is_aux) begin
            a_done  <= 1'b1;
            a_rdata <= mem_rdata;
          end else begin
            c_done  <= 1'b1;
            c_err   <= r_err;
            c_rdata <= (r_err | r_we) ? 32'd0 : w_rdata_ext;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural 1-cycle-latency word memory.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [2:0]  c_funct3 = 3'd0;
  logic [8:0]  c_addr = 9'd0;
  logic [31:0] c_wdata = 32'd0;
  logic [31:0] c_rdata;
  logic        c_done, c_err, c_stall;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [6:0]  a_addr = 7'd0;
  logic [31:0] a_wdata = 32'd0;
  logic [31:0] a_rdata;
  logic        a_done;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] tb_mem [128] = '{default: 32'd0};

  dmem_access_ctrl #(
    .DM_ADDRESS(9), .DATA_W(32), .ALLOW_MISALIGNED(1), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err), .c_stall(c_stall),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mem_rdata <= tb_mem[mem_addr];
    for (int i = 0; i < 4; i++)
      if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  typedef struct {int tag; logic err; logic [31:0] rd; logic chk_rd; int at;} rsp_t;
  typedef struct {logic [6:0] addr; logic [3:0] be; logic [31:0] data;} wr_t;

  rsp_t cq[$];
  rsp_t aq[$];
  wr_t  wq[$];

  int checks = 0, errors = 0;
  int tmo_cnt = 0, tmo_seen = 0, rst_req = 0, rst_seen = 0;
  bit fin_req = 1'b0, fin_done = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: the only process that compares.
  initial begin
    rsp_t r;
    wr_t  w;
    logic [31:0] m;
    forever begin
      @(negedge clk);
      if (rst_req != rst_seen) begin
        rst_seen++;
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_c_done", 32'(c_done), 32'd0);
        chk("rst_c_err", 32'(c_err), 32'd0);
        chk("rst_a_done", 32'(a_done), 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        $display("reset state sampled cyc=%0d", cyc);
      end
      if (tmo_cnt != tmo_seen) begin
        tmo_seen++;
        checks++;
        errors++;
        $display("FAIL timeout actual=no_done required=done (cyc %0d)", cyc);
      end
      if (c_req) chk("c_stall", 32'(c_stall), 32'(!c_done));
      if (mem_be != 4'd0) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=be %b word %0d required=no write", mem_be, mem_addr);
        end else begin
          w = wq.pop_front();
          m = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_be", 32'(mem_be), 32'(w.be));
          chk("wr_data", mem_wdata & m, w.data);
          $display("write beat word=%0d be=%b data=%h", mem_addr, mem_be, mem_wdata & m);
        end
      end
      if (c_done) begin
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_c_done actual=1 required=0 (cyc %0d)", cyc);
        end else begin
          r = cq.pop_front();
          chk($sformatf("c_err#%0d", r.tag), 32'(c_err), 32'(r.err));
          if (r.chk_rd) chk($sformatf("c_rdata#%0d", r.tag), c_rdata, r.rd);
          chk($sformatf("c_cycle#%0d", r.tag), 32'(cyc), 32'(r.at));
          $display("core #%0d done err=%0b rdata=%h cyc=%0d", r.tag, c_err, c_rdata, cyc);
        end
      end
      if (a_done) begin
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_a_done actual=1 required=0 (cyc %0d)", cyc);
        end else begin
          r = aq.pop_front();
          if (r.chk_rd) chk($sformatf("a_rdata#%0d", r.tag), a_rdata, r.rd);
          chk($sformatf("a_cycle#%0d", r.tag), 32'(cyc), 32'(r.at));
          $display("aux #%0d done rdata=%h cyc=%0d", r.tag, a_rdata, cyc);
        end
      end
      if (fin_req && !fin_done) begin
        chk("core_queue_left", 32'(cq.size()), 32'd0);
        chk("aux_queue_left", 32'(aq.size()), 32'd0);
        chk("write_queue_left", 32'(wq.size()), 32'd0);
        fin_done = 1'b1;
      end
    end
  end

  task automatic push_wr(input logic [6:0] addr, input logic [3:0] be, input logic [31:0] data);
    wr_t w;
    w.addr = addr; w.be = be; w.data = data;
    wq.push_back(w);
  endtask

  task automatic core_op(input int tag, input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, input logic e_err, input logic chk_rd,
                         input logic [31:0] e_rd, input int lat);
    rsp_t r;
    int n;
    @(negedge clk);
    r.tag = tag; r.err = e_err; r.rd = e_rd; r.chk_rd = chk_rd; r.at = cyc + lat;
    cq.push_back(r);
    c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (c_done) break;
      n++;
      if (n > 50) begin tmo_cnt++; break; end
    end
    c_req = 1'b0;
  endtask

  task automatic aux_op(input int tag, input logic we, input logic [6:0] addr, input logic [31:0] wd,
                        input logic chk_rd, input logic [31:0] e_rd);
    rsp_t r;
    int n;
    @(negedge clk);
    r.tag = tag; r.err = 1'b0; r.rd = e_rd; r.chk_rd = chk_rd; r.at = cyc + 3;
    aq.push_back(r);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (a_done) break;
      n++;
      if (n > 50) begin tmo_cnt++; break; end
    end
    a_req = 1'b0;
  endtask

  initial begin
    rsp_t r;
    int s;
    int n;
    repeat (2) @(negedge clk);
    rst_req++;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    push_wr(7'd4, 4'b1111, 32'hDEADBEEF);
    core_op(1, 1'b1, F3_W, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 3);
    core_op(2, 1'b0, F3_W, 9'h010, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF, 3);

    push_wr(7'd4, 4'b1111, 32'h80FF7F01);
    aux_op(3, 1'b1, 7'd4, 32'h80FF7F01, 1'b0, 32'd0);
    core_op(4, 1'b0, F3_B,  9'h013, 32'd0, 1'b0, 1'b1, 32'hFFFFFF80, 3);
    core_op(5, 1'b0, F3_BU, 9'h013, 32'd0, 1'b0, 1'b1, 32'h00000080, 3);
    core_op(6, 1'b0, F3_H,  9'h012, 32'd0, 1'b0, 1'b1, 32'hFFFF80FF, 3);
    core_op(7, 1'b0, F3_HU, 9'h012, 32'd0, 1'b0, 1'b1, 32'h000080FF, 3);
    aux_op(8, 1'b0, 7'd4, 32'd0, 1'b1, 32'h80FF7F01);

    push_wr(7'd4, 4'b1000, 32'h44000000);
    push_wr(7'd5, 4'b0111, 32'h00112233);
    core_op(9, 1'b1, F3_W, 9'h013, 32'h11223344, 1'b0, 1'b0, 32'd0, 4);
    core_op(10, 1'b0, F3_W, 9'h013, 32'd0, 1'b0, 1'b1, 32'h11223344, 4);

    core_op(11, 1'b1, F3_H, 9'h1FF, 32'h0000BEEF, 1'b1, 1'b1, 32'd0, 3);
    core_op(12, 1'b0, 3'b011, 9'h010, 32'd0, 1'b1, 1'b1, 32'd0, 3);
    core_op(13, 1'b1, F3_BU, 9'h010, 32'h000000AA, 1'b1, 1'b1, 32'd0, 3);
    core_op(14, 1'b0, F3_H, 9'h011, 32'd0, 1'b0, 1'b1, 32'hFFFFFF7F, 3);

    push_wr(7'd0, 4'b1000, 32'hB6000000);
    push_wr(7'd1, 4'b0001, 32'h000000A5);
    core_op(15, 1'b1, F3_H, 9'h003, 32'h0000A5B6, 1'b0, 1'b0, 32'd0, 4);
    core_op(16, 1'b0, F3_HU, 9'h003, 32'd0, 1'b0, 1'b1, 32'h0000A5B6, 4);

    // Core held continuously against a waiting aux read.
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < LIM; k++) begin
      r.tag = 20 + k; r.err = 1'b0; r.rd = 32'h00112233; r.chk_rd = 1'b1; r.at = s + 3 * (k + 1);
      cq.push_back(r);
    end
    r.tag = 30; r.err = 1'b0; r.rd = 32'h44FF7F01; r.chk_rd = 1'b1; r.at = s + 3 * (LIM + 1);
    aq.push_back(r);
    c_req = 1'b1; c_we = 1'b0; c_funct3 = F3_W; c_addr = 9'h014;
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'd4;
    n = 0;
    forever begin
      @(negedge clk);
      if (a_done) break;
      n++;
      if (n > 100) begin tmo_cnt++; break; end
    end
    a_req = 1'b0;
    c_req = 1'b0;

    // Reset while the second beat of a split store is on the bus.
    push_wr(7'd1, 4'b1000, 32'h0D000000);
    push_wr(7'd2, 4'b0111, 32'h00CAFEF0);
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_funct3 = F3_W; c_addr = 9'h007; c_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    c_req = 1'b0;
    @(negedge clk);
    rst_req++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    core_op(40, 1'b0, F3_W, 9'h004, 32'd0, 1'b0, 1'b1, 32'h0D0000A5, 3);
    core_op(41, 1'b0, F3_W, 9'h008, 32'd0, 1'b0, 1'b1, 32'h00000000, 3);

    repeat (5) @(negedge clk);
    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
